memory_dumper: RTL and testbench

Sequential read-back engine for the 256×8 program memory that the memory programmer fills. On a start pulse, it reads a run of bytes beginning at a given address through the memory's synchronous read port. Each byte is presented on a valid/ready byte stream toward the host-side link. A running 8-bit checksum lets the host confirm the image without a byte-by-byte compare.

---
 rtl/memory_dumper.sv | 89 ++++++++
 tb/tb_memory_dumper.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_dumper.sv
// Sequential read-back engine: reads a run of bytes from a synchronous-read memory
// and streams them out over valid/ready while accumulating an 8-bit checksum.
module memory_dumper #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_N,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] start_addr_in,
  input  logic [ADDR_WIDTH:0]   length_in,
  output logic                  rd_en_out,
  output logic [ADDR_WIDTH-1:0] address_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [DATA_WIDTH-1:0] checksum_out
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] SEND    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] checksum_q;
  logic [ADDR_WIDTH:0]   clamped_len;

  // A full-memory run is the longest meaningful request; anything larger saturates.
  assign clamped_len = (length_in > MAX_LEN) ? MAX_LEN : length_in;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let SEND see a half-updated count.
  always_ff @(posedge clock_in or negedge reset_N) begin
    if (!reset_N) begin
      state      <= IDLE;
      addr       <= '0;
      count      <= '0;
      data_q     <= '0;
      checksum_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            addr       <= start_addr_in;
            count      <= clamped_len;
            checksum_q <= '0;
            state      <= (clamped_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE:   state <= CAPTURE;
        CAPTURE: begin
          data_q <= mem_data_in;
          state  <= SEND;
        end
        SEND: begin
          if (ready_in) begin
            checksum_q <= checksum_q + data_q;
            addr       <= addr + 1'b1;
            count      <= count - 1'b1;
            // count still holds the pre-decrement value here
            state      <= (count == {{ADDR_WIDTH{1'b0}}, 1'b1}) ? DONE : ISSUE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registers only, so no input reaches an output combinationally.
  assign rd_en_out    = (state == ISSUE);
  assign valid_out    = (state == SEND);
  assign busy_out     = (state == ISSUE) || (state == CAPTURE) || (state == SEND);
  assign done_out     = (state == DONE);
  assign address_out  = addr;
  assign data_out     = data_q;
  assign checksum_out = checksum_q;

endmodule

// File: tb/tb_memory_dumper.sv
// Directed bench for memory_dumper: synchronous-read memory model mem[a]=a^0x5A,
// a negedge monitor logging transfers/reads/done, and hand-derived expectations.
module tb_memory_dumper;

  logic       clock_in = 1'b0;
  logic       reset_N = 1'b0;
  logic       start_in = 1'b0;
  logic [7:0] start_addr_in = '0;
  logic [8:0] length_in = '0;
  logic       rd_en_out;
  logic [7:0] address_out;
  logic [7:0] mem_data_in = '0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in = 1'b1;
  logic       busy_out;
  logic       done_out;
  logic [7:0] checksum_out;

  memory_dumper #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock_in(clock_in), .reset_N(reset_N), .start_in(start_in),
    .start_addr_in(start_addr_in), .length_in(length_in),
    .rd_en_out(rd_en_out), .address_out(address_out), .mem_data_in(mem_data_in),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy_out(busy_out), .done_out(done_out), .checksum_out(checksum_out)
  );

  always #5 clock_in = ~clock_in;

  function automatic logic [7:0] mem_val(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  always @(posedge clock_in) if (rd_en_out) mem_data_in <= mem_val(address_out);

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor log, cleared at each start.
  logic [7:0] xfer_q[$];
  int         xfer_cyc[$];
  logic [7:0] addr_q[$];
  int         done_cnt, done_cyc, first_valid, busy_cnt, e0;

  always @(negedge clock_in) begin
    if (reset_N) begin
      if (valid_out && first_valid < 0) first_valid = cyc;
      if (valid_out && ready_in) begin
        xfer_q.push_back(data_out);
        xfer_cyc.push_back(cyc + 1);
      end
      if (rd_en_out) addr_q.push_back(address_out);
      if (busy_out) busy_cnt++;
      if (done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic do_start(input logic [7:0] a, input logic [8:0] len);
    @(posedge clock_in); #1;
    start_in = 1'b1; start_addr_in = a; length_in = len;
    xfer_q.delete(); xfer_cyc.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1; busy_cnt = 0;
    @(posedge clock_in); #1;
    e0 = cyc;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clock_in); #1;
      if (done_cnt > 0) break;
    end
    if (k == budget) check("done_timeout", 0, 1);
  endtask

  task automatic wait_byte2_valid(input string tag);
    int k;
    for (k = 0; k < 100; k++) begin
      if (valid_out && xfer_q.size() == 1) break;
      @(posedge clock_in); #1;
    end
    if (k == 100) check({tag, "_timeout"}, 0, 1);
  endtask

  // n = number of bytes actually expected; timed = ready held high throughout.
  task automatic verify_run(input string tag, input logic [7:0] a, input int n, input bit timed);
    logic [7:0] sum = '0;
    logic [7:0] ad;
    check({tag, "_xfers"}, xfer_q.size(), n);
    check({tag, "_reads"}, addr_q.size(), n);
    for (int i = 0; i < n && i < xfer_q.size() && i < addr_q.size(); i++) begin
      ad = a + 8'(i);
      sum = sum + mem_val(ad);
      check($sformatf("%s_addr%0d", tag, i), addr_q[i], ad);
      check($sformatf("%s_byte%0d", tag, i), xfer_q[i], mem_val(ad));
      if (timed) check($sformatf("%s_xcyc%0d", tag, i), xfer_cyc[i] - e0, 3 * (i + 1));
    end
    check({tag, "_checksum"}, checksum_out, sum);
    check({tag, "_done_cnt"}, done_cnt, 1);
    if (timed) begin
      check({tag, "_done_cyc"}, done_cyc - e0, 3 * n);
      if (n > 0) check({tag, "_latency"}, first_valid - e0, 2);
      check({tag, "_busy_cyc"}, busy_cnt, 3 * n);
    end
  endtask

  initial begin
    // Reset: every output must be zero while held and until the first start.
    #12;
    check("rst_outs", {rd_en_out, address_out, data_out, valid_out, busy_out,
                       done_out, checksum_out}, '0);
    reset_N = 1'b1;
    repeat (3) @(posedge clock_in);
    #1;
    check("post_rst_outs", {rd_en_out, address_out, data_out, valid_out, busy_out,
                            done_out, checksum_out}, '0);

    // Basic run: 0x4A,0x4B,0x48,0x49 -> checksum 0x26.
    do_start(8'h10, 9'd4);
    wait_done(50);
    verify_run("basic", 8'h10, 4, 1'b1);
    check("basic_sum_const", checksum_out, 8'h26);

    // Empty run: done right after the start edge, no reads, checksum cleared.
    do_start(8'h33, 9'd0);
    wait_done(10);
    check("empty_done_cyc", done_cyc - e0, 0);
    verify_run("empty", 8'h33, 0, 1'b1);

    // Backpressure on byte 2 for 5 cycles.
    do_start(8'h10, 9'd4);
    wait_byte2_valid("bp");
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock_in); #1;
      check($sformatf("bp_hold%0d", i), {valid_out, rd_en_out, data_out}, {1'b1, 1'b0, 8'h4B});
    end
    ready_in = 1'b1;
    wait_done(50);
    verify_run("bp", 8'h10, 4, 1'b0);

    // Address wrap.
    do_start(8'hFE, 9'd4);
    wait_done(50);
    verify_run("wrap", 8'hFE, 4, 1'b1);

    // Oversized length clamps to a full 256-byte sweep; sum of all bytes is 0x80.
    do_start(8'h80, 9'd300);
    wait_done(1000);
    verify_run("clamp", 8'h80, 256, 1'b1);
    check("clamp_sum_const", checksum_out, 8'h80);

    // Reset in SEND of byte 2: outputs drop before the next edge, no done.
    do_start(8'h20, 9'd4);
    wait_byte2_valid("mrst");
    ready_in = 1'b0;
    #2 reset_N = 1'b0;
    #1 check("mrst_outs", {valid_out, busy_out, rd_en_out, done_out}, 4'b0000);
    repeat (2) @(posedge clock_in);
    #1 check("mrst_no_done", done_cnt, 0);
    reset_N = 1'b1;
    ready_in = 1'b1;
    do_start(8'h40, 9'd2);
    wait_done(50);
    verify_run("after_rst", 8'h40, 2, 1'b1);

    // Starts during a run and during DONE are ignored.
    do_start(8'h10, 9'd3);
    repeat (3) @(posedge clock_in);
    #1 start_in = 1'b1; start_addr_in = 8'h80; length_in = 9'd1;
    @(posedge clock_in); #1 start_in = 1'b0;
    for (int k = 0; k < 50 && !done_out; k++) begin
      @(posedge clock_in); #1;
    end
    check("ign_in_done", done_out, 1'b1);
    start_in = 1'b1; start_addr_in = 8'h90; length_in = 9'd2;
    @(posedge clock_in); #1 start_in = 1'b0;
    repeat (4) @(posedge clock_in);
    #1 check("ign_idle_busy", {busy_out, rd_en_out}, 2'b00);
    verify_run("ign", 8'h10, 3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
